// File: rtl/guess_checker.sv
// Serial Mastermind-style scorer: counts exact and colour-only pegs of each guess
// against the stored secret code and raises sticky win/lose flags.
module guess_checker #(
  parameter int NUM_PEGS    = 4,
  parameter int COLOR_W     = 3,
  parameter int MAX_GUESSES = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clear,
  input  logic                                  ld_code,
  input  logic [NUM_PEGS*COLOR_W-1:0]           code_in,
  input  logic                                  guess_valid,
  input  logic [NUM_PEGS*COLOR_W-1:0]           guess_in,
  output logic                                  guess_ready,
  output logic                                  result_valid,
  output logic [$clog2(NUM_PEGS+1)-1:0]         exact_count,
  output logic [$clog2(NUM_PEGS+1)-1:0]         color_count,
  output logic [$clog2(MAX_GUESSES+1)-1:0]      guesses_used,
  output logic                                  win,
  output logic                                  lose
);

  localparam int CODE_W = NUM_PEGS * COLOR_W;
  localparam int CNT_W  = $clog2(NUM_PEGS + 1);
  localparam int GU_W   = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W  = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PEGS - 1);
  localparam logic [GU_W-1:0]  MAX_GU    = GU_W'(MAX_GUESSES);
  localparam logic [CNT_W-1:0] ALL_EXACT = CNT_W'(NUM_PEGS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXACT = 2'd1,
    COLOR = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [CODE_W-1:0]   code_reg;
  // Snapshot of the code taken at acceptance, so a same-cycle reload scores against the old code
  logic [CODE_W-1:0]   work_code_reg;
  logic [CODE_W-1:0]   guess_reg;
  logic [NUM_PEGS-1:0] guess_matched_reg;
  logic [NUM_PEGS-1:0] code_matched_reg;
  logic [IDX_W-1:0]    idx_i_reg;
  logic [IDX_W-1:0]    idx_j_reg;
  logic [CNT_W-1:0]    exact_reg;
  logic [CNT_W-1:0]    color_reg;
  logic [GU_W-1:0]     guesses_reg;
  logic                win_reg;
  logic                lose_reg;

  logic [COLOR_W-1:0] guess_peg [NUM_PEGS];
  logic [COLOR_W-1:0] code_peg  [NUM_PEGS];

  generate
    for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_unpack
      assign guess_peg[gi] = guess_reg[gi*COLOR_W +: COLOR_W];
      assign code_peg[gi]  = work_code_reg[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  logic            accept;
  logic            last_pair;
  logic            exact_hit;
  logic            color_hit;
  logic [GU_W-1:0] guesses_inc;

  always_comb begin
    state_next   = state_reg;
    guess_ready  = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    last_pair    = 1'b0;
    exact_hit    = (guess_peg[idx_i_reg] == code_peg[idx_i_reg]);
    color_hit    = !guess_matched_reg[idx_i_reg] && !code_matched_reg[idx_j_reg] &&
                   (guess_peg[idx_i_reg] == code_peg[idx_j_reg]);
    guesses_inc  = (guesses_reg == MAX_GU) ? MAX_GU : guesses_reg + 1'b1;
    case (state_reg)
      IDLE: begin
        guess_ready = !win_reg && !lose_reg;
        if (guess_valid && guess_ready) begin
          accept     = 1'b1;
          state_next = EXACT;
        end
      end
      EXACT: begin
        if (idx_i_reg == LAST_IDX) state_next = COLOR;
      end
      COLOR: begin
        if (idx_i_reg == LAST_IDX && idx_j_reg == LAST_IDX) begin
          last_pair  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      code_reg          <= '0;
      work_code_reg     <= '0;
      guess_reg         <= '0;
      guess_matched_reg <= '0;
      code_matched_reg  <= '0;
      idx_i_reg         <= '0;
      idx_j_reg         <= '0;
      exact_reg         <= '0;
      color_reg         <= '0;
      guesses_reg       <= '0;
      win_reg           <= 1'b0;
      lose_reg          <= 1'b0;
    end else if (clear) begin
      state_reg         <= IDLE;
      code_reg          <= '0;
      work_code_reg     <= '0;
      guess_reg         <= '0;
      guess_matched_reg <= '0;
      code_matched_reg  <= '0;
      idx_i_reg         <= '0;
      idx_j_reg         <= '0;
      exact_reg         <= '0;
      color_reg         <= '0;
      guesses_reg       <= '0;
      win_reg           <= 1'b0;
      lose_reg          <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (ld_code) code_reg <= code_in;
          if (accept) begin
            guess_reg         <= guess_in;
            work_code_reg     <= code_reg;
            guess_matched_reg <= '0;
            code_matched_reg  <= '0;
            exact_reg         <= '0;
            color_reg         <= '0;
            idx_i_reg         <= '0;
            idx_j_reg         <= '0;
          end
        end
        EXACT: begin
          if (exact_hit) begin
            exact_reg                    <= exact_reg + 1'b1;
            guess_matched_reg[idx_i_reg] <= 1'b1;
            code_matched_reg[idx_i_reg]  <= 1'b1;
          end
          idx_i_reg <= (idx_i_reg == LAST_IDX) ? '0 : idx_i_reg + 1'b1;
        end
        COLOR: begin
          if (color_hit) begin
            color_reg                    <= color_reg + 1'b1;
            guess_matched_reg[idx_i_reg] <= 1'b1;
            code_matched_reg[idx_j_reg]  <= 1'b1;
          end
          if (idx_j_reg == LAST_IDX) begin
            idx_j_reg <= '0;
            idx_i_reg <= (idx_i_reg == LAST_IDX) ? '0 : idx_i_reg + 1'b1;
          end else begin
            idx_j_reg <= idx_j_reg + 1'b1;
          end
          // Flags and guess count settle on entry to DONE so they are fresh with result_valid
          if (last_pair) begin
            guesses_reg <= guesses_inc;
            if (exact_reg == ALL_EXACT) win_reg <= 1'b1;
            else if (guesses_inc == MAX_GU) lose_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign exact_count  = exact_reg;
  assign color_count  = color_reg;
  assign guesses_used = guesses_reg;
  assign win          = win_reg;
  assign lose         = lose_reg;

endmodule
